// File: rtl/pe_2in1out.sv
// Join PE: two FIFO-buffered token streams, consumed pairwise when both have data. The sum of
// each pair travels through a fixed-latency pipeline that stalls as one block on output backpressure.
module pe_2in1out #(
    parameter int WIDTH   = 16,
    parameter int LATENCY = 15,
    parameter int DEPTH   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in_1,
    input  logic             valid_in_1,
    output logic             ready_in_1,
    input  logic [WIDTH-1:0] data_in_2,
    input  logic             valid_in_2,
    output logic             ready_in_2,
    output logic [WIDTH-1:0] data_out_1,
    output logic             valid_out_1,
    input  logic             ready_out_1
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    // Modular sum: the carry out of the top bit is dropped.
    function automatic logic [WIDTH-1:0] wrap_sum(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] s;
        s = a + b;
        return s;
    endfunction

    logic [WIDTH-1:0] din  [2];
    logic [WIDTH-1:0] head [2];
    logic [1:0]       valid;
    logic [1:0]       ready;
    logic [1:0]       push;
    logic [1:0]       has_tok;
    logic             stall;
    logic             fire;

    assign din[0]     = data_in_1;
    assign din[1]     = data_in_2;
    assign valid      = {valid_in_2, valid_in_1};
    assign ready_in_1 = ready[0];
    assign ready_in_2 = ready[1];

    for (genvar s = 0; s < 2; s++) begin : g_fifo
        logic [WIDTH-1:0] mem [DEPTH];
        logic [AW-1:0]    wr_ptr;
        logic [AW-1:0]    rd_ptr;
        logic [CW-1:0]    count;

        // Ready comes from the registered count only, so a pop never frees a full FIFO in the same cycle.
        assign ready[s]   = !rst && (count < CW'(DEPTH));
        assign push[s]    = valid[s] && ready[s];
        assign has_tok[s] = (count != '0);
        assign head[s]    = mem[rd_ptr];

        always_ff @(posedge clk) begin
            if (push[s]) begin
                mem[wr_ptr] <= din[s];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push[s]) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (fire) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({push[s], fire})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    logic [WIDTH-1:0] data_p [LATENCY];
    logic             vld_p  [LATENCY];

    assign data_out_1  = data_p[LATENCY-1];
    assign valid_out_1 = vld_p[LATENCY-1];
    assign stall       = valid_out_1 && !ready_out_1;
    assign fire        = has_tok[0] && has_tok[1] && !stall;

    // Stage 0 takes the pair sum (or a zero bubble); later stages shift unless the output is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < LATENCY; k++) begin
                data_p[k] <= '0;
                vld_p[k]  <= 1'b0;
            end
        end else if (!stall) begin
            vld_p[0]  <= fire;
            data_p[0] <= fire ? wrap_sum(head[0], head[1]) : '0;
            for (int k = 1; k < LATENCY; k++) begin
                data_p[k] <= data_p[k-1];
                vld_p[k]  <= vld_p[k-1];
            end
        end
    end

endmodule

// File: tb/tb_pe_2in1out.sv
// Bench for pe_2in1out: scenario tasks against a queue-based pairing model, plus a LATENCY=1/DEPTH=2 build.
`timescale 1ns/1ps
module tb_pe_2in1out;
    localparam int W   = 16;
    localparam int LAT = 15;
    localparam int DEP = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] data_in_1, data_in_2, data_out_1;
    logic         valid_in_1, valid_in_2, ready_in_1, ready_in_2, valid_out_1, ready_out_1;

    logic         s_rst;
    logic [W-1:0] s_d1, s_d2, s_dout;
    logic         s_v1, s_v2, s_r1, s_r2, s_vout, s_rout;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int hs_viol = 0;
    bit rand_sink = 0;

    logic [W-1:0] src1[$], src2[$], acc1[$], acc2[$], got[$];
    int           got_cyc[$];
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_data  = '0;

    pe_2in1out #(.WIDTH(W), .LATENCY(LAT), .DEPTH(DEP)) dut (
        .clk(clk), .rst(rst),
        .data_in_1(data_in_1), .valid_in_1(valid_in_1), .ready_in_1(ready_in_1),
        .data_in_2(data_in_2), .valid_in_2(valid_in_2), .ready_in_2(ready_in_2),
        .data_out_1(data_out_1), .valid_out_1(valid_out_1), .ready_out_1(ready_out_1)
    );

    pe_2in1out #(.WIDTH(W), .LATENCY(1), .DEPTH(2)) dut_small (
        .clk(clk), .rst(s_rst),
        .data_in_1(s_d1), .valid_in_1(s_v1), .ready_in_1(s_r1),
        .data_in_2(s_d2), .valid_in_2(s_v2), .ready_in_2(s_r2),
        .data_out_1(s_dout), .valid_out_1(s_vout), .ready_out_1(s_rout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Observe handshakes mid-cycle; they complete at the following rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (valid_in_1 && ready_in_1) acc1.push_back(data_in_1);
            if (valid_in_2 && ready_in_2) acc2.push_back(data_in_2);
            if (valid_out_1 && ready_out_1) begin
                got.push_back(data_out_1);
                got_cyc.push_back(cyc);
            end
            if (prev_stall && !(valid_out_1 === 1'b1 && data_out_1 === prev_data))
                hs_viol <= hs_viol + 1;
        end
        prev_stall <= !rst && valid_out_1 && !ready_out_1;
        prev_data  <= data_out_1;
    end

    function automatic logic [W-1:0] model_sum(input int k);
        return acc1[k] + acc2[k];
    endfunction

    task automatic clear_logs();
        acc1.delete(); acc2.delete(); got.delete(); got_cyc.delete();
        src1.delete(); src2.delete();
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pump(input int budget);
        int c = 0;
        bit a1, a2;
        while ((src1.size() > 0 || src2.size() > 0) && c < budget) begin
            if (rand_sink) ready_out_1 = 1'($urandom_range(0, 1));
            valid_in_1 = (src1.size() > 0) && (!rand_sink || $urandom_range(0, 3) != 0);
            data_in_1  = (src1.size() > 0) ? src1[0] : '0;
            valid_in_2 = (src2.size() > 0) && (!rand_sink || $urandom_range(0, 3) != 0);
            data_in_2  = (src2.size() > 0) ? src2[0] : '0;
            @(negedge clk);
            a1 = valid_in_1 && ready_in_1;
            a2 = valid_in_2 && ready_in_2;
            tick();
            if (a1) void'(src1.pop_front());
            if (a2) void'(src2.pop_front());
            c++;
        end
        valid_in_1 = 1'b0;
        valid_in_2 = 1'b0;
    endtask

    task automatic drain(input int n, input int budget);
        int c = 0;
        while (got.size() < n && c < budget) begin
            if (rand_sink) ready_out_1 = 1'($urandom_range(0, 1));
            tick();
            c++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        total++; if (ready_in_1 !== 1'b0) begin bad++; $display("FAIL rst_ready1 got=%b exp=0", ready_in_1); end
        total++; if (ready_in_2 !== 1'b0) begin bad++; $display("FAIL rst_ready2 got=%b exp=0", ready_in_2); end
        total++; if (valid_out_1 !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", valid_out_1); end
        total++; if (data_out_1 !== 16'h0000) begin bad++; $display("FAIL rst_data got=%h exp=0000", data_out_1); end
        tick();
        rst = 1'b0;
        @(negedge clk);
        total++; if (ready_in_1 !== 1'b1) begin bad++; $display("FAIL post_rst_ready1 got=%b exp=1", ready_in_1); end
        total++; if (ready_in_2 !== 1'b1) begin bad++; $display("FAIL post_rst_ready2 got=%b exp=1", ready_in_2); end
        tick();
    endtask

    task automatic test_single_pair();
        int  n = 0;
        bit  seen = 0;
        bit  acc_ok;
        clear_logs();
        ready_out_1 = 1'b1;
        data_in_1 = 16'h0003; data_in_2 = 16'h0004;
        valid_in_1 = 1'b1; valid_in_2 = 1'b1;
        @(negedge clk);
        acc_ok = ready_in_1 && ready_in_2;
        tick();
        valid_in_1 = 1'b0; valid_in_2 = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            if (valid_out_1 === 1'b1) seen = 1;
            else begin tick(); n++; end
        end
        total++; if (acc_ok !== 1'b1) begin bad++; $display("FAIL single_accept got=%b exp=1", acc_ok); end
        total++; if (n !== LAT) begin bad++; $display("FAIL single_latency got=%0d exp=%0d", n, LAT); end
        total++; if (data_out_1 !== 16'h0007) begin bad++; $display("FAIL single_data got=%h exp=0007", data_out_1); end
        tick();
        @(negedge clk);
        total++; if (valid_out_1 !== 1'b0) begin bad++; $display("FAIL single_one_cycle got=%b exp=0", valid_out_1); end
        tick();
    endtask

    task automatic test_wrap_stream();
        int errs = 0;
        int gaps = 0;
        logic [W-1:0] v;
        clear_logs();
        src1.push_back(16'hFFFF); src2.push_back(16'h0002);
        pump(20);
        drain(1, 40);
        v = (got.size() > 0) ? got[0] : 'x;
        total++; if (v !== 16'h0001) begin bad++; $display("FAIL wrap_sum got=%h exp=0001", v); end
        clear_logs();
        for (int i = 0; i < 20; i++) begin
            src1.push_back(16'(i));
            src2.push_back(16'(2 * i));
        end
        pump(100);
        drain(20, 100);
        for (int k = 0; k < got.size(); k++) if (got[k] !== 16'(3 * k)) errs++;
        for (int k = 1; k < got_cyc.size(); k++) if (got_cyc[k] - got_cyc[k-1] != 1) gaps++;
        total++; if (got.size() !== 20) begin bad++; $display("FAIL stream_count got=%0d exp=20", got.size()); end
        total++; if (errs !== 0) begin bad++; $display("FAIL stream_values wrong=%0d exp=0", errs); end
        total++; if (gaps !== 0) begin bad++; $display("FAIL stream_gaps got=%0d exp=0", gaps); end
    endtask

    task automatic test_backpressure();
        int holdbad = 0;
        int errs = 0;
        clear_logs();
        ready_out_1 = 1'b0;
        src1.push_back(16'h0008); src2.push_back(16'h0008);
        for (int i = 1; i < 25; i++) begin
            src1.push_back(16'($urandom));
            src2.push_back(16'($urandom));
        end
        pump(40);
        @(negedge clk);
        total++; if (ready_in_1 !== 1'b0) begin bad++; $display("FAIL bp_ready1 got=%b exp=0", ready_in_1); end
        total++; if (ready_in_2 !== 1'b0) begin bad++; $display("FAIL bp_ready2 got=%b exp=0", ready_in_2); end
        total++; if (acc1.size() !== LAT + DEP) begin bad++; $display("FAIL bp_accepted1 got=%0d exp=%0d", acc1.size(), LAT + DEP); end
        total++; if (acc2.size() !== LAT + DEP) begin bad++; $display("FAIL bp_accepted2 got=%0d exp=%0d", acc2.size(), LAT + DEP); end
        for (int i = 0; i < 10; i++) begin
            tick();
            @(negedge clk);
            if (!(valid_out_1 === 1'b1 && data_out_1 === 16'h0010)) holdbad++;
        end
        total++; if (holdbad !== 0) begin bad++; $display("FAIL bp_hold bad_cycles=%0d exp=0 data=%h", holdbad, data_out_1); end
        total++; if (got.size() !== 0) begin bad++; $display("FAIL bp_no_transfer got=%0d exp=0", got.size()); end
        tick();
        ready_out_1 = 1'b1;
        pump(100);
        drain(25, 200);
        for (int k = 0; k < got.size() && k < acc1.size() && k < acc2.size(); k++)
            if (got[k] !== model_sum(k)) errs++;
        total++; if (got.size() !== 25) begin bad++; $display("FAIL bp_drain_count got=%0d exp=25", got.size()); end
        total++; if (errs !== 0) begin bad++; $display("FAIL bp_drain_order wrong=%0d exp=0", errs); end
    endtask

    task automatic test_unbalanced();
        int errs = 0;
        clear_logs();
        ready_out_1 = 1'b1;
        for (int i = 1; i <= 5; i++) src1.push_back(16'(i));
        pump(10);
        @(negedge clk);
        total++; if (acc1.size() !== DEP) begin bad++; $display("FAIL unbal_accepted got=%0d exp=%0d", acc1.size(), DEP); end
        total++; if (ready_in_1 !== 1'b0) begin bad++; $display("FAIL unbal_ready1 got=%b exp=0", ready_in_1); end
        tick();
        for (int i = 0; i < 5; i++) src2.push_back(16'h0010);
        pump(60);
        drain(5, 60);
        for (int k = 0; k < got.size(); k++) if (got[k] !== 16'(16'h0011 + k)) errs++;
        total++; if (got.size() !== 5) begin bad++; $display("FAIL unbal_count got=%0d exp=5", got.size()); end
        total++; if (errs !== 0) begin bad++; $display("FAIL unbal_values wrong=%0d exp=0", errs); end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] v;
        clear_logs();
        ready_out_1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            src1.push_back(16'($urandom));
            src2.push_back(16'($urandom));
        end
        pump(20);
        for (int i = 0; i < 3; i++) src1.push_back(16'($urandom));
        pump(10);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++; if (got.size() !== 0) begin bad++; $display("FAIL rmid_early_out got=%0d exp=0", got.size()); end
        total++; if (valid_out_1 !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b exp=0", valid_out_1); end
        total++; if (data_out_1 !== 16'h0000) begin bad++; $display("FAIL rmid_data got=%h exp=0000", data_out_1); end
        tick();
        rst = 1'b0;
        clear_logs();
        repeat (40) tick();
        total++; if (got.size() !== 0) begin bad++; $display("FAIL rmid_stale got=%0d exp=0", got.size()); end
        src1.push_back(16'h000A); src2.push_back(16'h000B);
        pump(10);
        drain(1, 40);
        repeat (20) tick();
        v = (got.size() > 0) ? got[0] : 'x;
        total++; if (got.size() !== 1) begin bad++; $display("FAIL rmid_count got=%0d exp=1", got.size()); end
        total++; if (v !== 16'h0015) begin bad++; $display("FAIL rmid_value got=%h exp=0015", v); end
    endtask

    task automatic test_random();
        int errs = 0;
        clear_logs();
        rand_sink = 1;
        for (int i = 0; i < 40; i++) begin
            src1.push_back(16'($urandom));
            src2.push_back(16'($urandom));
        end
        pump(600);
        drain(40, 800);
        rand_sink = 0;
        ready_out_1 = 1'b1;
        for (int k = 0; k < got.size() && k < acc1.size() && k < acc2.size(); k++)
            if (got[k] !== model_sum(k)) errs++;
        total++; if (got.size() !== 40) begin bad++; $display("FAIL rand_count got=%0d exp=40", got.size()); end
        total++; if (errs !== 0) begin bad++; $display("FAIL rand_values wrong=%0d exp=0", errs); end
        total++; if (hs_viol !== 0) begin bad++; $display("FAIL rand_out_stable violations=%0d exp=0", hs_viol); end
    endtask

    task automatic test_small_build();
        int  n_acc = 0;
        bit  acc_ok;
        s_rout = 1'b1;
        repeat (2) tick();
        s_rst = 1'b0;
        s_d1 = 16'h0003; s_d2 = 16'h0004; s_v1 = 1'b1; s_v2 = 1'b1;
        @(negedge clk);
        acc_ok = s_r1 && s_r2;
        tick();
        s_v1 = 1'b0; s_v2 = 1'b0;
        @(negedge clk);
        total++; if (acc_ok !== 1'b1) begin bad++; $display("FAIL small_accept got=%b exp=1", acc_ok); end
        total++; if (s_vout !== 1'b0) begin bad++; $display("FAIL small_early got=%b exp=0", s_vout); end
        tick();
        @(negedge clk);
        total++; if (!(s_vout === 1'b1 && s_dout === 16'h0007)) begin bad++; $display("FAIL small_result got=%b/%h exp=1/0007", s_vout, s_dout); end
        tick();
        s_v1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_d1 = 16'($urandom);
            @(negedge clk);
            if (s_r1) n_acc++;
            tick();
        end
        s_v1 = 1'b0;
        @(negedge clk);
        total++; if (n_acc !== 2) begin bad++; $display("FAIL small_full_accepts got=%0d exp=2", n_acc); end
        total++; if (s_r1 !== 1'b0) begin bad++; $display("FAIL small_full_ready got=%b exp=0", s_r1); end
        tick();
    endtask

    initial begin
        rst = 1'b1; s_rst = 1'b1;
        data_in_1 = '0; data_in_2 = '0; valid_in_1 = 1'b0; valid_in_2 = 1'b0; ready_out_1 = 1'b1;
        s_d1 = '0; s_d2 = '0; s_v1 = 1'b0; s_v2 = 1'b0; s_rout = 1'b1;
        test_reset();
        test_single_pair();
        test_wrap_stream();
        test_backpressure();
        test_unbalanced();
        test_reset_mid();
        test_random();
        test_small_build();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule
